// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the pipeline port
// (absolute, zero-latency priority) and a secondary req/ack requester.
// Tracks read ownership so read data is steered to the right master, and
// raises an informational starvation flag for the secondary port.
// Optional build macro MEMARB_PROTECT_EN: blocks secondary writes below
// PROTECT_TOP (still acked, memory request suppressed, dma_err pulses).
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 16,
  parameter logic [31:0] PROTECT_TOP  = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cpu_valid,
  input  logic        cpu_write,
  input  logic [3:0]  cpu_wmask,
  input  logic [31:0] cpu_wdata,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_write,
  input  logic [3:0]  dma_wmask,
  input  logic [31:0] dma_wdata,
  input  logic [31:0] dma_addr,
  output logic        dma_ack,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic        dma_starve,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata
);

  // Counter must hold STARVE_LIMIT and is never narrower than 5 bits.
  localparam int unsigned CNT_W =
    ($clog2(STARVE_LIMIT + 1) > 32'd5) ? $clog2(STARVE_LIMIT + 1) : 32'd5;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

`ifdef MEMARB_PROTECT_EN
  localparam logic PROT_EN = 1'b1;
`else
  localparam logic PROT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    OWN_NONE   = 2'b00,
    OWN_CPU_RD = 2'b01,
    OWN_DMA_RD = 2'b10
  } owner_e;

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             starve_q;
  logic             err_q;
  logic             dma_blocked_s;

  // Combinational grant: pipeline first, secondary only on idle cycles.
  always_comb begin
    mem_valid     = 1'b0;
    mem_write     = cpu_write;
    mem_wmask     = cpu_wmask;
    mem_wdata     = cpu_wdata;
    mem_addr      = cpu_addr;
    dma_ack       = 1'b0;
    dma_blocked_s = 1'b0;
    if (cpu_valid) begin
      mem_valid = 1'b1;
    end else if (dma_req) begin
      dma_ack       = 1'b1;
      mem_write     = dma_write;
      mem_wmask     = dma_wmask;
      mem_wdata     = dma_wdata;
      mem_addr      = dma_addr;
      dma_blocked_s = PROT_EN & dma_write & (dma_addr < PROTECT_TOP);
      mem_valid     = ~dma_blocked_s;
    end else begin
      mem_valid = 1'b0;
    end
  end

  // Owner next state: whichever granted request is a read owns next cycle's data.
  always_comb begin
    owner_d = OWN_NONE;
    if (cpu_valid) begin
      owner_d = cpu_write ? OWN_NONE : OWN_CPU_RD;
    end else if (dma_req) begin
      owner_d = dma_write ? OWN_NONE : OWN_DMA_RD;
    end else begin
      owner_d = OWN_NONE;
    end
  end

  // Owner state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Output decode of the owner: secondary data strobe.
  always_comb begin
    dma_rvalid = 1'b0;
    case (owner_q)
      OWN_DMA_RD: dma_rvalid = 1'b1;
      default:    dma_rvalid = 1'b0;
    endcase
  end

  // Starvation counter next value: count denied cycles, saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (!dma_req || dma_ack) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == LIMIT) begin
      cnt_d = LIMIT;
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter, starvation flag and blocked-write pulse registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= {CNT_W{1'b0}};
      starve_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      starve_q <= (cnt_d == LIMIT);
      err_q    <= dma_blocked_s;
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;
  assign dma_err    = err_q;
  assign dma_starve = starve_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int LIM = 4;
  localparam logic [31:0] PTOP = 32'h0000_1000;
`ifdef MEMARB_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk, rstn;
  logic        cpu_valid, cpu_write, dma_req, dma_write;
  logic [3:0]  cpu_wmask, dma_wmask;
  logic [31:0] cpu_wdata, cpu_addr, dma_wdata, dma_addr;
  logic [31:0] cpu_rdata, dma_rdata, mem_rdata, mem_wdata, mem_addr;
  logic        dma_ack, dma_rvalid, dma_err, dma_starve, mem_valid, mem_write;
  logic [3:0]  mem_wmask;

  mem_port_arbiter #(.STARVE_LIMIT(LIM), .PROTECT_TOP(PTOP)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_valid(cpu_valid), .cpu_write(cpu_write), .cpu_wmask(cpu_wmask),
    .cpu_wdata(cpu_wdata), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_write(dma_write), .dma_wmask(dma_wmask),
    .dma_wdata(dma_wdata), .dma_addr(dma_addr), .dma_ack(dma_ack),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .dma_starve(dma_starve), .mem_valid(mem_valid), .mem_write(mem_write),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory behind the arbiter: one-cycle read latency, byte-masked writes.
  logic [31:0] mem_arr [0:4095];
  // Reference shadow of what memory should contain.
  logic [31:0] shad [0:4095];

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_valid) begin
      if (mem_write) mem_arr[mem_addr[13:2]] <= merge(mem_arr[mem_addr[13:2]], mem_wdata, mem_wmask);
      else           mem_rdata <= mem_arr[mem_addr[13:2]];
    end
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference model state: what the registered outputs should show this cycle.
  bit          m_dma_rv, m_cpu_rv, m_err, m_starve;
  logic [31:0] m_rd;
  int          m_cnt;

  task automatic m_reset();
    m_dma_rv = 1'b0; m_cpu_rv = 1'b0; m_err = 1'b0; m_starve = 1'b0;
    m_cnt = 0; m_rd = 32'h0;
  endtask

  // One clock cycle: drive, check against the model, advance the model, clock.
  task automatic step(input logic cv, input logic cw, input logic [3:0] cm,
                      input logic [31:0] cd, input logic [31:0] ca,
                      input logic dr, input logic dw, input logic [3:0] dm,
                      input logic [31:0] dd, input logic [31:0] da);
    bit e_cpu, e_dma, e_blk, e_mem;
    cpu_valid = cv; cpu_write = cw; cpu_wmask = cm; cpu_wdata = cd; cpu_addr = ca;
    dma_req = dr; dma_write = dw; dma_wmask = dm; dma_wdata = dd; dma_addr = da;
    #1;
    e_cpu = cv;
    e_dma = !cv && dr;
    e_blk = e_dma && dw && PROT && (da < PTOP);
    e_mem = e_cpu || (e_dma && !e_blk);
    chk1("dma_ack", dma_ack, e_dma);
    chk1("mem_valid", mem_valid, e_mem);
    if (e_mem) begin
      chk32("mem_addr", mem_addr, e_cpu ? ca : da);
      chk1("mem_write", mem_write, e_cpu ? cw : dw);
      chk32("mem_wdata", mem_wdata, e_cpu ? cd : dd);
      chk32("mem_wmask", {28'd0, mem_wmask}, {28'd0, (e_cpu ? cm : dm)});
    end else if (!e_dma) begin
      chk32("idle_mem_addr", mem_addr, ca);
    end
    chk1("dma_rvalid", dma_rvalid, m_dma_rv);
    if (m_dma_rv) chk32("dma_rdata", dma_rdata, m_rd);
    if (m_dma_rv || m_cpu_rv) chk32("cpu_rdata", cpu_rdata, m_rd);
    chk1("dma_err", dma_err, m_err);
    chk1("dma_starve", dma_starve, m_starve);
    // Advance the model across the coming edge.
    m_dma_rv = 1'b0; m_cpu_rv = 1'b0; m_err = 1'b0;
    if (e_cpu) begin
      if (cw) shad[ca[13:2]] = merge(shad[ca[13:2]], cd, cm);
      else begin m_cpu_rv = 1'b1; m_rd = shad[ca[13:2]]; end
    end else if (e_dma) begin
      if (dw) begin
        if (!e_blk) shad[da[13:2]] = merge(shad[da[13:2]], dd, dm);
        m_err = e_blk;
      end else begin
        m_dma_rv = 1'b1; m_rd = shad[da[13:2]];
      end
    end
    if (dr && !e_dma) m_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
    else m_cnt = 0;
    m_starve = (m_cnt == LIM);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, 4'hF, d, a, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic dma_wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 4'hF, d, a);
  endtask

  task automatic dma_rd(input logic [31:0] a);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, a);
  endtask

  task automatic both_rd(input logic [31:0] ca, input logic [31:0] da);
    step(1'b1, 1'b0, 4'h0, 32'h0, ca, 1'b1, 1'b0, 4'h0, 32'h0, da);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] base;
    case ($urandom_range(0, 3))
      0:       base = 32'h0000_0FF0;
      1:       base = 32'h0000_1000;
      2:       base = 32'h0000_2000;
      default: base = 32'h0000_0100;
    endcase
    return base + 32'(4 * $urandom_range(0, 3));
  endfunction

  initial begin
    logic        p_pend, p_w, cv, cw;
    logic [3:0]  p_m, cm;
    logic [31:0] p_d, p_a, cd, ca;
    for (int i = 0; i < 4096; i++) begin mem_arr[i] = 32'h0; shad[i] = 32'h0; end
    mem_rdata = 32'h0;
    m_reset();
    rstn = 1'b0;
    cpu_valid = 1'b0; cpu_write = 1'b0; cpu_wmask = 4'h0; cpu_wdata = 32'h0; cpu_addr = 32'h0;
    dma_req = 1'b0; dma_write = 1'b0; dma_wmask = 4'h0; dma_wdata = 32'h0; dma_addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_rvalid", dma_rvalid, 1'b0);
    chk1("rst_err", dma_err, 1'b0);
    chk1("rst_starve", dma_starve, 1'b0);
    chk1("rst_mem_valid", mem_valid, 1'b0);
    rstn = 1'b1;

    // Seed memory through the pipeline port.
    cpu_wr(32'h0000_0100, 32'h1234_5678);
    cpu_wr(32'h0000_0FFC, 32'h1111_1111);

    // Secondary port alone: write then read back.
    dma_wr(32'h0000_2000, 32'hDEAD_BEEF);
    dma_rd(32'h0000_2000);
    chk1("plan_rvalid", dma_rvalid, 1'b1);
    chk32("plan_rdata", dma_rdata, 32'hDEAD_BEEF);
    idle();
    chk1("plan_rvalid_single", dma_rvalid, 1'b0);

    // Collision: pipeline wins for three cycles, secondary acks on the fourth.
    for (int i = 0; i < 3; i++) begin
      both_rd(32'h0000_0100, 32'h0000_2000);
      chk32("coll_cpu_rdata", cpu_rdata, 32'h1234_5678);
      chk1("coll_no_rvalid", dma_rvalid, 1'b0);
    end
    dma_rd(32'h0000_2000);
    chk1("coll_rvalid", dma_rvalid, 1'b1);
    chk32("coll_dma_rdata", dma_rdata, 32'hDEAD_BEEF);
    idle();

    // Starvation with the pipeline held busy.
    for (int i = 1; i <= 5; i++) begin
      both_rd(32'h0000_0100, 32'h0000_2000);
      chk1("starve_flag", dma_starve, (i >= 4) ? 1'b1 : 1'b0);
    end
    dma_rd(32'h0000_2000);
    chk1("starve_clear", dma_starve, 1'b0);
    idle();

    // Protected region write, read back, and a write just at the boundary.
    dma_wr(32'h0000_0FFC, 32'hA5A5_A5A5);
    chk1("prot_err", dma_err, PROT);
    dma_rd(32'h0000_0FFC);
    chk32("prot_rdata", dma_rdata, PROT ? 32'h1111_1111 : 32'hA5A5_A5A5);
    dma_wr(32'h0000_1000, 32'h0BAD_F00D);
    chk1("prot_top_err", dma_err, 1'b0);
    dma_rd(32'h0000_1000);
    chk32("prot_top_rdata", dma_rdata, 32'h0BAD_F00D);
    idle();

    // Back-to-back secondary writes then reads.
    for (int i = 0; i < 4; i++) dma_wr(32'h0000_2000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      dma_rd(32'h0000_2000 + 32'(4 * i));
      chk1("b2b_rvalid", dma_rvalid, 1'b1);
      chk32("b2b_rdata", dma_rdata, 32'hC0DE_0000 + 32'(i));
    end
    idle();
    chk1("b2b_rvalid_end", dma_rvalid, 1'b0);

    // Reset in the middle of an acked read with the starvation flag set.
    for (int i = 0; i < 5; i++) both_rd(32'h0000_0100, 32'h0000_2008);
    dma_req = 1'b1; dma_write = 1'b0; dma_addr = 32'h0000_2008; cpu_valid = 1'b0;
    #1;
    chk1("rstmid_ack", dma_ack, 1'b1);
    chk1("rstmid_starve_pre", dma_starve, 1'b1);
    rstn = 1'b0;
    #1;
    chk1("rstmid_rvalid", dma_rvalid, 1'b0);
    chk1("rstmid_err", dma_err, 1'b0);
    chk1("rstmid_starve", dma_starve, 1'b0);
    chk1("rstmid_ack_comb", dma_ack, 1'b1);
    @(posedge clk);
    #1;
    chk1("rstmid_rvalid_edge", dma_rvalid, 1'b0);
    dma_req = 1'b0;
    rstn = 1'b1;
    m_reset();
    idle();
    chk1("rstmid_rvalid_after", dma_rvalid, 1'b0);
    chk1("rstmid_starve_after", dma_starve, 1'b0);

    // Randomized traffic; secondary fields held stable until acked.
    p_pend = 1'b0; p_w = 1'b0; p_m = 4'h0; p_d = 32'h0; p_a = 32'h0;
    for (int n = 0; n < 500; n++) begin
      if (!p_pend && ($urandom_range(0, 2) != 0)) begin
        p_pend = 1'b1;
        p_w = 1'($urandom_range(0, 1));
        p_m = 4'($urandom_range(0, 15));
        p_d = $urandom;
        p_a = rnd_addr();
      end
      cv = ($urandom_range(0, 9) < 6);
      cw = 1'($urandom_range(0, 1));
      cm = 4'($urandom_range(0, 15));
      cd = $urandom;
      ca = rnd_addr();
      step(cv, cw, cm, cd, ca, p_pend, p_w, p_m, p_d, p_a);
      if (!cv) p_pend = 1'b0;
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
